// File: rtl/seq_sched_pkg.sv
// Shared encodings and sizing helper for the seq_detect_sched block.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } sched_state_e;

  typedef enum logic [2:0] {
    DetC0,
    DetZ1,
    DetZ2,
    DetO1,
    DetO2
  } det_state_e;

  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_bit_detector.sv
// Serial "001"/"111" detector; history is tracked as runs of equal bits.
module seq_bit_detector
  import seq_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DetC0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clr) begin
      state_d = DetC0;
    end else if (bit_valid) begin
      if (bit_in) begin
        // A 1 after a run of at least two equal bits completes 001 or 111.
        hit     = (state_q == DetZ2) || (state_q == DetO2);
        state_d = ((state_q == DetO1) || (state_q == DetO2)) ? DetO2 : DetO1;
      end else begin
        state_d = ((state_q == DetZ1) || (state_q == DetZ2)) ? DetZ2 : DetZ1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin share of one serial pattern detector between two requesters.
// Define SEQ_SCHED_LSB_FIRST_EN to shift words LSB first (default MSB first).
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready,
  output logic             busy
);

  sched_state_e     state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_valid, grant_id;
  logic             bit_cur, hit, det_clr, det_valid;
  logic [WIDTH-1:0] shreg_next;

`ifdef SEQ_SCHED_LSB_FIRST_EN
  assign bit_cur    = shreg_q[0];
  assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
`else
  assign bit_cur    = shreg_q[WIDTH-1];
  assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
`endif

  // rr_q names the requester favoured when both are valid.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = (req0_valid && req1_valid) ? rr_q : req1_valid;
  end

  seq_bit_detector u_det (
    .clk      (clk),
    .reset    (reset),
    .clr      (det_clr),
    .bit_valid(det_valid),
    .bit_in   (bit_cur),
    .hit      (hit)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    det_clr    = 1'b0;
    det_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          det_clr    = 1'b1;
          shreg_d    = grant_id ? req1_data : req0_data;
          id_d       = grant_id;
          idx_d      = '0;
          cnt_d      = '0;
          rr_d       = ~grant_id;
          state_d    = StShift;
        end
      end
      StShift: begin
        det_valid = 1'b1;
        shreg_d   = shreg_next;
        if (hit) cnt_d = cnt_q + CNT_W'(1);
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          state_d = StReport;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      StReport: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StReport);
  assign res_id    = id_q;
  assign res_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomized bench for seq_detect_sched against a transaction-level reference model.
module tb_seq_detect_sched;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready;
  logic             res_valid, res_id, res_ready = 1'b0, busy;
  logic [CNT_W-1:0] res_count;

  always #5 clk = ~clk;

  seq_detect_sched #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_count (res_count),
    .res_ready (res_ready),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a word occupies the block from its handshake cycle until its result
  // handshake; the result appears WIDTH+1 cycles after the handshake.
  bit m_busy = 0;
  int m_t    = 0;
  bit m_rr   = 0;
  bit m_id   = 0;
  int m_cnt  = 0;
  bit hs0, hs1;
  int mode   = 4;

  logic [WIDTH-1:0] dir_w [4];
  int               dir_e [4];
  int               dir_i = 0;
  int               dir_exp_q[$];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Hits in a word: each 1 whose two preceding in-word bits are equal.
  function automatic int ref_hits(input logic [WIDTH-1:0] w);
    logic b [WIDTH];
    int h = 0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef SEQ_SCHED_LSB_FIRST_EN
      b[i] = w[i];
`else
      b[i] = w[WIDTH-1-i];
`endif
    end
    for (int i = 2; i < WIDTH; i++) if (b[i] && (b[i-1] == b[i-2])) h++;
    return h;
  endfunction

  task automatic step();
    int  g;
    bit  exp_rv;
    @(negedge clk);
    if (m_busy) m_t++;
    exp_rv = m_busy && (m_t >= WIDTH + 1);
    g = -1;
    if (!m_busy) begin
      if (req0_valid && req1_valid) g = int'(m_rr);
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    check_eq("req0_ready", int'(req0_ready), int'(g == 0));
    check_eq("req1_ready", int'(req1_ready), int'(g == 1));
    check_eq("busy", int'(busy), int'(m_busy));
    check_eq("res_valid", int'(res_valid), int'(exp_rv));
    if (exp_rv) begin
      check_eq("res_id", int'(res_id), int'(m_id));
      check_eq("res_count", int'(res_count), m_cnt);
    end
    hs0 = (g == 0);
    hs1 = (g == 1);
    if (g >= 0) begin
      m_busy = 1;
      m_t    = 0;
      m_id   = (g == 1);
      m_rr   = (g == 0);
      if (mode == 0 && dir_exp_q.size() > 0) m_cnt = dir_exp_q.pop_front();
      else m_cnt = ref_hits((g == 1) ? req1_data : req0_data);
    end else if (exp_rv && res_ready) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_next();
    if (hs0) req0_valid = 1'b0;
    if (hs1) req1_valid = 1'b0;
    case (mode)
      0: begin
        res_ready  = 1'b1;
        req1_valid = 1'b0;
        if (!req0_valid && dir_i < 4) begin
          req0_valid = 1'b1;
          req0_data  = dir_w[dir_i];
          dir_exp_q.push_back(dir_e[dir_i]);
          dir_i++;
        end
      end
      1: begin
        res_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'hFF;
        req1_valid = 1'b1;
        req1_data  = 8'h24;
      end
      2: begin
        // Data of an ungranted requester may wander; only the handshake value counts.
        if (!req0_valid) req0_valid = ($urandom_range(3) != 0);
        if ($urandom_range(2) == 0) req0_data = WIDTH'($urandom);
        if (!req1_valid) req1_valid = ($urandom_range(3) != 0);
        if ($urandom_range(2) == 0) req1_data = WIDTH'($urandom);
        res_ready = 1'($urandom_range(1));
      end
      3: begin
        if (!req0_valid) req0_data = WIDTH'($urandom);
        if (!req1_valid) req1_data = WIDTH'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = m_busy && (m_t + 1 >= WIDTH + 6);
      end
      default: begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
      end
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      drive_next();
    end
  endtask

  initial begin
    dir_w[0] = 8'b00100111;
    dir_w[1] = 8'hFF;
    dir_w[2] = 8'b01100100;
    dir_w[3] = 8'h00;
`ifdef SEQ_SCHED_LSB_FIRST_EN
    dir_e[0] = 2; dir_e[1] = 6; dir_e[2] = 2; dir_e[3] = 0;
`else
    dir_e[0] = 3; dir_e[1] = 6; dir_e[2] = 1; dir_e[3] = 0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_res_valid", int'(res_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_res_id", int'(res_id), 0);
    check_eq("rst_res_count", int'(res_count), 0);
    check_eq("rst_req0_ready", int'(req0_ready), 0);
    check_eq("rst_req1_ready", int'(req1_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    mode = 0;
    drive_next();
    run(60);
    check_eq("directed_words_done", dir_exp_q.size() + (4 - dir_i), 0);

    mode = 1;
    drive_next();
    run(50);
    mode = 4;
    drive_next();
    run(15);

    // Reset during the 4th SHIFT cycle drops the word.
    req0_valid = 1'b1;
    req0_data  = 8'hFF;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    step();
    req0_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_res_valid", int'(res_valid), 0);
    m_busy = 0;
    m_rr   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req0_data  = 8'b00100111;
    req1_valid = 1'b1;
    req1_data  = 8'hFF;
    step();
    drive_next();
    run(15);

    mode = 3;
    drive_next();
    run(80);
    mode = 2;
    drive_next();
    run(2000);
    mode = 4;
    drive_next();
    run(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
